move_selector: RTL



---
 rtl/move_pkg.sv | 38 +++
 rtl/move_selector_best_tracker.sv | 72 +++++++
 rtl/move_selector.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/move_pkg.sv
// Shared definitions for the paper-soccer move selector: compass directions,
// controller states, default tie-break orders and goal-shot directions.
package move_pkg;

  localparam logic [2:0] DIR_A = 3'd0;
  localparam logic [2:0] DIR_B = 3'd1;
  localparam logic [2:0] DIR_C = 3'd2;
  localparam logic [2:0] DIR_D = 3'd3;
  localparam logic [2:0] DIR_E = 3'd4;
  localparam logic [2:0] DIR_F = 3'd5;
  localparam logic [2:0] DIR_G = 3'd6;
  localparam logic [2:0] DIR_H = 3'd7;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GOAL_CHK,
    S_MEM_WAIT,
    S_MEM_READ,
    S_EVAL_WAIT,
    S_EVAL_ISSUE,
    S_EVAL_RUN,
    S_DECIDE,
    S_RESULT
  } state_t;

  // Leftmost entry is the highest priority.
  localparam logic [23:0] PRIO_RED_DEF  = {DIR_E, DIR_D, DIR_F, DIR_C, DIR_G, DIR_B, DIR_H, DIR_A};
  localparam logic [23:0] PRIO_BLUE_DEF = {DIR_A, DIR_B, DIR_H, DIR_C, DIR_G, DIR_D, DIR_F, DIR_E};

  // Shots for ball x = h+1 / h / h-1 on the attacked goal line.
  localparam logic [2:0] GOAL_BLUE_HI  = DIR_H;
  localparam logic [2:0] GOAL_BLUE_MID = DIR_A;
  localparam logic [2:0] GOAL_BLUE_LO  = DIR_B;
  localparam logic [2:0] GOAL_RED_HI   = DIR_F;
  localparam logic [2:0] GOAL_RED_MID  = DIR_E;
  localparam logic [2:0] GOAL_RED_LO   = DIR_D;

endpackage

// File: rtl/move_selector_best_tracker.sv
// Running-best register for the direction search, with the per-colour
// tie-break rank comparator.
module best_tracker
  import move_pkg::*;
#(
  parameter int unsigned NUM_DIR = 8,
  parameter int unsigned DIR_W   = 3,
  parameter int unsigned VAL_W   = 8,
  parameter logic [NUM_DIR*DIR_W-1:0] PRIO_RED  = PRIO_RED_DEF,
  parameter logic [NUM_DIR*DIR_W-1:0] PRIO_BLUE = PRIO_BLUE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             update,
  input  logic [VAL_W-1:0] score,
  input  logic [DIR_W-1:0] dir,
  input  logic             bonus,
  input  logic             color,
  output logic             best_valid,
  output logic [DIR_W-1:0] best_dir,
  output logic             best_bonus
);

  logic             valid_q;
  logic [VAL_W-1:0] score_q;
  logic [DIR_W-1:0] dir_q;
  logic             bonus_q;

  logic [NUM_DIR*DIR_W-1:0] prio;
  logic [DIR_W-1:0]         cand_rank;
  logic [DIR_W-1:0]         best_rank;
  logic                     take;

  function automatic logic [DIR_W-1:0] rank_of(input logic [NUM_DIR*DIR_W-1:0] list,
                                               input logic [DIR_W-1:0]         d);
    rank_of = '0;
    for (int unsigned i = 0; i < NUM_DIR; i++) begin
      if (list[(NUM_DIR-1-i)*DIR_W +: DIR_W] == d) rank_of = DIR_W'(i);
    end
  endfunction

  always_comb begin
    prio      = color ? PRIO_RED : PRIO_BLUE;
    cand_rank = rank_of(prio, dir);
    best_rank = rank_of(prio, dir_q);
    take      = update && (!valid_q || (score > score_q) ||
                           ((score == score_q) && (cand_rank < best_rank)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      score_q <= '0;
      dir_q   <= '0;
      bonus_q <= 1'b0;
    end else if (clear) begin
      valid_q <= 1'b0;
      score_q <= '0;
    end else if (take) begin
      valid_q <= 1'b1;
      score_q <= score;
      dir_q   <= dir;
      bonus_q <= bonus;
    end
  end

  assign best_valid = valid_q;
  assign best_dir   = dir_q;
  assign best_bonus = bonus_q;

endmodule

// File: rtl/move_selector.sv
// Move-decision controller: takes the goal shot when available, otherwise
// evaluates every direction through the shared evaluator and reports the best.
module move_selector
  import move_pkg::*;
#(
  parameter  int unsigned NUM_DIR = 8,
  localparam int unsigned DIR_W   = $clog2(NUM_DIR),
  parameter  int unsigned VAL_W   = 8,
  parameter  int unsigned COORD_W = 8,
  parameter  logic [NUM_DIR*DIR_W-1:0] PRIO_RED  = PRIO_RED_DEF,
  parameter  logic [NUM_DIR*DIR_W-1:0] PRIO_BLUE = PRIO_BLUE_DEF,
  parameter  logic [DIR_W-1:0] FALLBACK_DIR = DIR_W'(2),
  parameter  logic GOAL_CHECK = 1'b1,
  parameter  int unsigned EVAL_TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               turn_req,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic [COORD_W-1:0] width,
  input  logic [COORD_W-1:0] length,
  input  logic               color,
  input  logic               mem_idle,
  input  logic               mem_done,
  output logic               mem_start,
  input  logic               eval_idle,
  input  logic               eval_done,
  input  logic               eval_no_perm,
  input  logic [VAL_W-1:0]   eval_score,
  input  logic               eval_bonus,
  output logic               eval_start,
  output logic [DIR_W-1:0]   eval_dir,
  output logic [DIR_W-1:0]   dir_out,
  output logic               bonus_out,
  output logic               dir_valid,
  output logic               goal_flag,
  output logic               idle
);

  localparam int unsigned TO_W = (EVAL_TIMEOUT > 0) ? $clog2(EVAL_TIMEOUT + 1) : 1;
  localparam logic        GOAL_EN = GOAL_CHECK && (NUM_DIR == 8);

  state_t             state_q, state_d;
  logic [DIR_W-1:0]   idx_q, idx_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [COORD_W-1:0] width_q, width_d, length_q, length_d;
  logic               color_q, color_d;
  logic [DIR_W-1:0]   dir_q, dir_d;
  logic               bonus_q, bonus_d;
  logic               goal_q, goal_d;

  logic               trk_clear, trk_update, step;
  logic               best_valid, best_bonus;
  logic [DIR_W-1:0]   best_dir;

  logic [COORD_W-1:0] half;
  logic               shot_hit;
  logic [DIR_W-1:0]   shot_dir;

  always_comb begin
    half     = width_q >> 1;
    shot_hit = color_q ? (pos_y_q == '0) : (pos_y_q == length_q);
    shot_dir = '0;
    if (pos_x_q == half + COORD_W'(1))
      shot_dir = color_q ? DIR_W'(GOAL_RED_HI) : DIR_W'(GOAL_BLUE_HI);
    else if (pos_x_q == half)
      shot_dir = color_q ? DIR_W'(GOAL_RED_MID) : DIR_W'(GOAL_BLUE_MID);
    else if (pos_x_q == half - COORD_W'(1))
      shot_dir = color_q ? DIR_W'(GOAL_RED_LO) : DIR_W'(GOAL_BLUE_LO);
    else
      shot_hit = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    to_d       = to_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    width_d    = width_q;
    length_d   = length_q;
    color_d    = color_q;
    dir_d      = dir_q;
    bonus_d    = bonus_q;
    goal_d     = goal_q;
    trk_clear  = 1'b0;
    trk_update = 1'b0;
    step       = 1'b0;
    unique case (state_q)
      S_IDLE: if (turn_req) begin
        pos_x_d   = pos_x;
        pos_y_d   = pos_y;
        width_d   = width;
        length_d  = length;
        color_d   = color;
        goal_d    = 1'b0;
        trk_clear = 1'b1;
        state_d   = S_GOAL_CHK;
      end
      S_GOAL_CHK: begin
        if (GOAL_EN && shot_hit) begin
          goal_d  = 1'b1;
          dir_d   = shot_dir;
          bonus_d = 1'b0;
          state_d = S_RESULT;
        end else begin
          state_d = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT:  if (mem_idle) state_d = S_MEM_READ;
      S_MEM_READ:  if (mem_done) state_d = S_EVAL_WAIT;
      S_EVAL_WAIT: if (eval_idle) begin
        idx_d   = '0;
        state_d = S_EVAL_ISSUE;
      end
      S_EVAL_ISSUE: begin
        to_d    = '0;
        state_d = S_EVAL_RUN;
      end
      S_EVAL_RUN: begin
        // eval_done takes precedence over no_perm and timeout.
        if (eval_done) begin
          trk_update = 1'b1;
          step       = 1'b1;
        end else if (eval_no_perm || (to_q == TO_W'(EVAL_TIMEOUT))) begin
          step = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
        if (step) begin
          if (idx_q == DIR_W'(NUM_DIR - 1)) begin
            state_d = S_DECIDE;
          end else begin
            idx_d   = idx_q + DIR_W'(1);
            state_d = S_EVAL_ISSUE;
          end
        end
      end
      S_DECIDE: begin
        dir_d   = best_valid ? best_dir : FALLBACK_DIR;
        bonus_d = best_valid ? best_bonus : 1'b0;
        state_d = S_RESULT;
      end
      S_RESULT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      to_q     <= '0;
      pos_x_q  <= '0;
      pos_y_q  <= '0;
      width_q  <= '0;
      length_q <= '0;
      color_q  <= 1'b0;
      dir_q    <= '0;
      bonus_q  <= 1'b0;
      goal_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      to_q     <= to_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      width_q  <= width_d;
      length_q <= length_d;
      color_q  <= color_d;
      dir_q    <= dir_d;
      bonus_q  <= bonus_d;
      goal_q   <= goal_d;
    end
  end

  best_tracker #(
    .NUM_DIR  (NUM_DIR),
    .DIR_W    (DIR_W),
    .VAL_W    (VAL_W),
    .PRIO_RED (PRIO_RED),
    .PRIO_BLUE(PRIO_BLUE)
  ) u_best (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (trk_clear),
    .update    (trk_update),
    .score     (eval_score),
    .dir       (idx_q),
    .bonus     (eval_bonus),
    .color     (color_q),
    .best_valid(best_valid),
    .best_dir  (best_dir),
    .best_bonus(best_bonus)
  );

  assign mem_start  = (state_q == S_MEM_READ);
  assign eval_start = (state_q == S_EVAL_ISSUE);
  assign eval_dir   = idx_q;
  assign dir_out    = dir_q;
  assign bonus_out  = bonus_q;
  assign dir_valid  = (state_q == S_RESULT);
  assign goal_flag  = goal_q;
  assign idle       = (state_q == S_IDLE);

endmodule
